// File: rtl/mem_arbiter.sv
// Two-client line-memory arbiter: serialises data-cache and instruction-fetch line
// transactions onto one datamem port, data first with a bounded starvation streak.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WIDTH-1:0] mem_readdata,
  input  logic                  mem_ready
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_owner_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [STREAK_W-1:0]   r_streak;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic                  w_starved;
  logic                  w_done;
  logic                  w_unused;

  // Byte offsets inside a line never reach the memory port.
  assign w_unused  = ^{d_addr[3:0], i_addr[3:0]};
  assign w_starved = (r_streak == STREAK_W'(MAX_DATA_STREAK));
  assign w_done    = (r_state == ST_BUSY) && mem_ready;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (d_req && !(i_req && w_starved)) begin
          w_grant_d = 1'b1;
        end else if (i_req) begin
          w_grant_i = 1'b1;
        end
        if (w_grant_d || w_grant_i) begin
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_d_rdata <= '0;
      r_i_rdata <= '0;
      r_streak  <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_we      <= d_we;
        r_addr    <= {d_addr[ADDR_WIDTH-1:4], 4'b0};
        r_wdata   <= d_we ? d_wdata : '0;
        if (i_req && !w_starved) begin
          r_streak <= r_streak + STREAK_W'(1);
        end
      end else if (w_grant_i) begin
        r_owner_d <= 1'b0;
        r_we      <= 1'b0;
        r_addr    <= {i_addr[ADDR_WIDTH-1:4], 4'b0};
        r_wdata   <= '0;
        r_streak  <= '0;
      end
      if (w_done) begin
        r_we <= 1'b0;
        if (!r_we) begin
          if (r_owner_d) begin
            r_d_rdata <= mem_readdata;
          end else begin
            r_i_rdata <= mem_readdata;
          end
        end
      end
    end
  end

  assign mem_req        = (r_state == ST_BUSY);
  assign WriteEnable    = r_we;
  assign memory_address = r_addr;
  assign mem_writedata  = r_wdata;
  assign d_ready        = (r_state == ST_RESP) && r_owner_d;
  assign i_ready        = (r_state == ST_RESP) && !r_owner_d;
  assign d_rdata        = r_d_rdata;
  assign i_rdata        = r_i_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/idle corner
// sequences, then randomized traffic against a transaction-level memory/arbiter model.
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_req, d_we, i_req, mem_ready;
  logic [31:0]  d_addr, i_addr;
  logic [127:0] d_wdata, mem_readdata;
  logic [127:0] d_rdata, i_rdata, mem_writedata;
  logic         d_ready, i_ready, mem_req, WriteEnable;
  logic [31:0]  memory_address;

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic         i_req;
    logic [31:0]  i_addr;
    logic [127:0] line;
    int           lat;
    logic         exp_d;
    logic [31:0]  exp_addr;
  } vec_t;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] m_d_rdata = '0;
  logic [127:0] m_i_rdata = '0;
  int           m_streak = 0;
  logic [127:0] mem_model [logic [31:0]];
  vec_t         vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dr, input logic dw, input logic [31:0] da,
                              input logic [127:0] dd, input logic ir, input logic [31:0] ia,
                              input logic [127:0] ln, input int lat, input logic ed,
                              input logic [31:0] ea);
    vec_t v;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.i_req = ir; v.i_addr = ia; v.line = ln; v.lat = lat;
    v.exp_d = ed; v.exp_addr = ea;
    return v;
  endfunction

  // Starts in an IDLE cycle, runs one whole transaction, ends in the following IDLE cycle.
  task automatic run_one(input vec_t v);
    logic         exp_we;
    logic [127:0] exp_wd;
    exp_we = v.exp_d ? v.d_we : 1'b0;
    exp_wd = (v.exp_d && v.d_we) ? v.d_wdata : '0;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    i_req = v.i_req; i_addr = v.i_addr;
    @(posedge clk); #1;
    check("grant_mem_req", mem_req, 1'b1);
    check("grant_we", WriteEnable, exp_we);
    check("grant_addr", memory_address, v.exp_addr);
    check("grant_wdata", mem_writedata, exp_wd);
    check("busy_no_ready", {d_ready, i_ready}, 2'b00);
    for (int k = 1; k < v.lat; k++) begin
      @(posedge clk); #1;
      check("busy_hold_req", mem_req, 1'b1);
      check("busy_hold_addr", memory_address, v.exp_addr);
      check("busy_hold_we", WriteEnable, exp_we);
      check("busy_no_ready", {d_ready, i_ready}, 2'b00);
    end
    mem_readdata = v.line;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    if (!exp_we) begin
      if (v.exp_d) m_d_rdata = v.line;
      else         m_i_rdata = v.line;
    end
    check("resp_d_ready", d_ready, v.exp_d);
    check("resp_i_ready", i_ready, !v.exp_d);
    check("resp_d_rdata", d_rdata, m_d_rdata);
    check("resp_i_rdata", i_rdata, m_i_rdata);
    check("resp_mem_req", {mem_req, WriteEnable}, 2'b00);
    if (v.exp_d) d_req = 1'b0;
    else         i_req = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", {d_ready, i_ready}, 2'b00);
  endtask

  initial begin
    logic         dp, ip, dwe, wd;
    logic [31:0]  da, ia, a;
    logic [127:0] dwd, ln;

    rst = 1'b1; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_addr = '0; mem_ready = 0; mem_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {mem_req, WriteEnable, d_ready, i_ready, memory_address}, '0);
    check("reset_rdata", d_rdata | i_rdata | mem_writedata, '0);
    rst = 1'b0;

    vecs[0]  = mk(1, 0, 32'h0000_1234, '0, 0, '0,
                  128'hDEADBEEF_00112233_44556677_8899BEEF, 3, 1, 32'h0000_1230);
    vecs[1]  = mk(1, 1, 32'h0000_0040, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 0, '0,
                  128'hFFFF, 1, 1, 32'h0000_0040);
    vecs[2]  = mk(0, 0, '0, '0, 1, 32'hBFC0_0008, 128'hC0DE_0001, 2, 0, 32'hBFC0_0000);
    vecs[3]  = mk(1, 0, 32'h0000_0104, '0, 1, 32'h0000_2008, 128'hA3, 1, 1, 32'h0000_0100);
    vecs[4]  = mk(0, 0, '0, '0, 1, 32'h0000_2008, 128'hA4, 1, 0, 32'h0000_2000);
    vecs[5]  = mk(1, 0, 32'h0000_0310, '0, 1, 32'h0000_3000, 128'hB5, 1, 1, 32'h0000_0310);
    vecs[6]  = mk(1, 0, 32'h0000_0320, '0, 1, 32'h0000_3000, 128'hB6, 2, 1, 32'h0000_0320);
    vecs[7]  = mk(1, 1, 32'h0000_0330, 128'h77, 1, 32'h0000_3000, 128'hB7, 1, 1, 32'h0000_0330);
    vecs[8]  = mk(1, 0, 32'h0000_0340, '0, 1, 32'h0000_3000, 128'hB8, 1, 1, 32'h0000_0340);
    vecs[9]  = mk(1, 0, 32'h0000_0350, '0, 1, 32'h0000_3000, 128'hB9, 1, 0, 32'h0000_3000);
    vecs[10] = mk(1, 0, 32'h0000_0350, '0, 1, 32'h0000_300C, 128'hBA, 1, 1, 32'h0000_0350);
    for (int n = 0; n < 11; n++) run_one(vecs[n]);

    // Reset in the middle of a read, then a stray mem_ready must return nothing.
    i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
    @(posedge clk); #1;
    check("pre_reset_busy", mem_req, 1'b1);
    rst = 1'b1; d_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_outputs", {mem_req, WriteEnable, d_ready, i_ready, memory_address}, '0);
    check("midreset_rdata", d_rdata | i_rdata | mem_writedata, '0);
    m_d_rdata = '0; m_i_rdata = '0; m_streak = 0;
    mem_readdata = 128'h1234; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_ready_ignored", {d_ready, i_ready, mem_req}, 3'b000);
      check("stray_rdata", d_rdata, '0);
      @(posedge clk); #1;
    end

    dp = 0; ip = 0; da = '0; ia = '0; dwe = 0; dwd = '0;
    for (int n = 0; n < 80; n++) begin
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dwe = 1'($urandom_range(0, 1));
        da = {$urandom_range(0, 15), $urandom_range(0, 15)} << 4 | 32'($urandom_range(0, 15));
        dwd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1;
        ia = {$urandom_range(0, 15), $urandom_range(0, 15)} << 4 | 32'($urandom_range(0, 15));
      end
      if (!dp && !ip) begin
        d_req = 0; i_req = 0;
        @(posedge clk); #1;
        check("idle_no_req", {mem_req, d_ready, i_ready}, 3'b000);
        continue;
      end
      wd = dp && !(ip && m_streak == MAXS);
      if (wd) begin
        if (ip && m_streak < MAXS) m_streak++;
      end else begin
        m_streak = 0;
      end
      a  = (wd ? da : ia) & 32'hFFFF_FFF0;
      ln = mem_model.exists(a) ? mem_model[a] : {4{a ^ 32'h5A5A_5A5A}};
      run_one(mk(dp, dwe, da, dwd, ip, ia, ln, $urandom_range(1, 4), wd, a));
      if (wd && dwe) mem_model[a] = dwd;
      if (wd) dp = 0;
      else    ip = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
